// File: rtl/fifo2stream_wide_pkg.sv
// Shared helpers for the wide FIFO-to-stream unpacker: lane layout and index sizing.
package fifo2stream_wide_pkg;

  localparam int unsigned DATA_OFS = 0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned lane_width(input int unsigned p);
    return p + 2;
  endfunction

  function automatic int unsigned sof_ofs(input int unsigned p);
    return p;
  endfunction

  function automatic int unsigned eol_ofs(input int unsigned p);
    return p + 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned beats);
    return (clog2(beats) > 1) ? clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fifo2stream_lane_chk.sv
// Splits one output beat into pixel data and sideband, and flags misplaced sof/eol.
module fifo2stream_lane_chk
  import fifo2stream_wide_pkg::*;
#(
  parameter int unsigned C_PIXEL_WIDTH = 8,
  parameter int unsigned C_OUT_PIXELS  = 1
) (
  input  logic [C_OUT_PIXELS*lane_width(C_PIXEL_WIDTH)-1:0] beat,
  output logic [C_OUT_PIXELS*C_PIXEL_WIDTH-1:0]             tdata,
  output logic                                              tuser,
  output logic                                              tlast,
  output logic                                              frame_err
);

  localparam int unsigned P   = C_PIXEL_WIDTH;
  localparam int unsigned L   = lane_width(C_PIXEL_WIDTH);
  localparam int unsigned SOF = sof_ofs(C_PIXEL_WIDTH);
  localparam int unsigned EOL = eol_ofs(C_PIXEL_WIDTH);
  localparam int unsigned N   = C_OUT_PIXELS;

  always_comb begin
    tdata     = '0;
    frame_err = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      tdata[k*P +: P] = beat[k*L + DATA_OFS +: P];
      // sof belongs only on the first lane, eol only on the last lane of a beat
      if (k != 0 && beat[k*L + SOF]) frame_err = 1'b1;
      if (k != N - 1 && beat[k*L + EOL]) frame_err = 1'b1;
    end
  end

  assign tuser = beat[SOF];
  assign tlast = beat[(N-1)*L + EOL];

endmodule

// File: rtl/fifo2stream_wide.sv
// Pops packed words from an FWFT FIFO and emits them as multi-pixel AXI4-Stream beats,
// with framing-error detection, soft flush and a frame counter.
module fifo2stream_wide
  import fifo2stream_wide_pkg::*;
#(
  parameter int unsigned C_PIXEL_WIDTH = 8,
  parameter int unsigned C_IN_PIXELS   = 4,
  parameter int unsigned C_OUT_PIXELS  = 1,
  parameter int unsigned C_FCNT_WIDTH  = 16
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                empty,
  input  logic [C_IN_PIXELS*lane_width(C_PIXEL_WIDTH)-1:0]    rd_data,
  output logic                                                rd_en,
  input  logic                                                flush,
  input  logic                                                clr_err,
  output logic                                                m_axis_tvalid,
  output logic [C_OUT_PIXELS*C_PIXEL_WIDTH-1:0]               m_axis_tdata,
  output logic                                                m_axis_tuser,
  output logic                                                m_axis_tlast,
  input  logic                                                m_axis_tready,
  output logic                                                err_framing,
  output logic [C_FCNT_WIDTH-1:0]                             frame_cnt
);

  localparam int unsigned L       = lane_width(C_PIXEL_WIDTH);
  localparam int unsigned C_BEATS = C_IN_PIXELS / C_OUT_PIXELS;
  localparam int unsigned IW      = idx_width(C_BEATS);
  localparam int unsigned BW      = C_OUT_PIXELS * L;
  localparam logic [IW-1:0] LAST_IDX = IW'(C_BEATS - 1);

  logic [C_IN_PIXELS*L-1:0] hold;
  logic                     hv;
  logic [IW-1:0]            idx;
  logic [BW-1:0]            beat;
  logic                     mnext;
  logic                     lastbeat;
  logic                     frame_err;

  assign m_axis_tvalid = hv;
  assign mnext         = hv & m_axis_tready;
  assign lastbeat      = (idx == LAST_IDX);
  // Reloading on the last accepted beat keeps the stream gap-free across words
  assign rd_en         = ~reset & ~empty & ~flush & (~hv | (mnext & lastbeat));

  always_comb begin
    beat = '0;
    for (int unsigned b = 0; b < C_BEATS; b++) begin
      if (idx == IW'(b)) beat = hold[b*BW +: BW];
    end
  end

  fifo2stream_lane_chk #(
    .C_PIXEL_WIDTH (C_PIXEL_WIDTH),
    .C_OUT_PIXELS  (C_OUT_PIXELS)
  ) u_lane_chk (
    .beat      (beat),
    .tdata     (m_axis_tdata),
    .tuser     (m_axis_tuser),
    .tlast     (m_axis_tlast),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold <= '0;
      hv   <= 1'b0;
      idx  <= '0;
    end else if (flush) begin
      hv  <= 1'b0;
      idx <= '0;
    end else if (rd_en) begin
      hold <= rd_data;
      hv   <= 1'b1;
      idx  <= '0;
    end else if (mnext) begin
      if (lastbeat) hv <= 1'b0;
      else          idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_framing <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (mnext && frame_err) err_framing <= 1'b1;
      else if (clr_err)       err_framing <= 1'b0;
      if (mnext && m_axis_tlast) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo2stream_wide.sv
// Directed bench: 2-beat configuration (P=8, IN=4, OUT=2) plus a 1-beat configuration with a 2-bit frame counter.
module tb_fifo2stream_wide;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- DUT A: OUT=2 ----------------
  logic        reset_a, empty_a, rd_en_a, flush_a, clr_a;
  logic [39:0] rd_data_a;
  logic        tvalid_a, tuser_a, tlast_a, tready_a, err_a;
  logic [15:0] tdata_a;
  logic [15:0] fcnt_a;

  logic [39:0] mem_a [0:31];
  int          wa = 0, ra = 0, rd_pulses_a = 0;
  assign empty_a   = (ra == wa);
  assign rd_data_a = mem_a[ra];
  always @(posedge clk) if (rd_en_a) begin
    ra          <= ra + 1;
    rd_pulses_a <= rd_pulses_a + 1;
  end

  fifo2stream_wide #(
    .C_PIXEL_WIDTH (8),
    .C_IN_PIXELS   (4),
    .C_OUT_PIXELS  (2),
    .C_FCNT_WIDTH  (16)
  ) dut_a (
    .clk           (clk),
    .reset         (reset_a),
    .empty         (empty_a),
    .rd_data       (rd_data_a),
    .rd_en         (rd_en_a),
    .flush         (flush_a),
    .clr_err       (clr_a),
    .m_axis_tvalid (tvalid_a),
    .m_axis_tdata  (tdata_a),
    .m_axis_tuser  (tuser_a),
    .m_axis_tlast  (tlast_a),
    .m_axis_tready (tready_a),
    .err_framing   (err_a),
    .frame_cnt     (fcnt_a)
  );

  // ---------------- DUT B: OUT=4, 2-bit frame counter ----------------
  logic        reset_b, empty_b, rd_en_b, flush_b, clr_b;
  logic [39:0] rd_data_b;
  logic        tvalid_b, tuser_b, tlast_b, tready_b, err_b;
  logic [31:0] tdata_b;
  logic [1:0]  fcnt_b;

  logic [39:0] mem_b [0:31];
  int          wb = 0, rb = 0;
  assign empty_b   = (rb == wb);
  assign rd_data_b = mem_b[rb];
  always @(posedge clk) if (rd_en_b) rb <= rb + 1;

  fifo2stream_wide #(
    .C_PIXEL_WIDTH (8),
    .C_IN_PIXELS   (4),
    .C_OUT_PIXELS  (4),
    .C_FCNT_WIDTH  (2)
  ) dut_b (
    .clk           (clk),
    .reset         (reset_b),
    .empty         (empty_b),
    .rd_data       (rd_data_b),
    .rd_en         (rd_en_b),
    .flush         (flush_b),
    .clr_err       (clr_b),
    .m_axis_tvalid (tvalid_b),
    .m_axis_tdata  (tdata_b),
    .m_axis_tuser  (tuser_b),
    .m_axis_tlast  (tlast_b),
    .m_axis_tready (tready_b),
    .err_framing   (err_b),
    .frame_cnt     (fcnt_b)
  );

  // ---------------- helpers ----------------
  function automatic logic [9:0] ln(input logic [7:0] d, input logic s, input logic e);
    return {e, s, d};
  endfunction

  function automatic logic [39:0] wd(input logic [9:0] l0, input logic [9:0] l1,
                                     input logic [9:0] l2, input logic [9:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic push_a(input logic [39:0] w);
    mem_a[wa] = w;
    wa++;
  endtask

  task automatic push_b(input logic [39:0] w);
    mem_b[wb] = w;
    wb++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat_a(input string tag, input logic [15:0] d, input logic u, input logic l);
    check({tag, "_valid"}, {63'd0, tvalid_a}, 64'd1);
    check({tag, "_data"},  {48'd0, tdata_a}, {48'd0, d});
    check({tag, "_user"},  {63'd0, tuser_a}, {63'd0, u});
    check({tag, "_last"},  {63'd0, tlast_a}, {63'd0, l});
  endtask

  task automatic beat_b(input string tag, input logic [31:0] d, input logic [1:0] fc, input logic rd);
    check({tag, "_valid"}, {63'd0, tvalid_b}, 64'd1);
    check({tag, "_data"},  {32'd0, tdata_b}, {32'd0, d});
    check({tag, "_user"},  {63'd0, tuser_b}, 64'd1);
    check({tag, "_last"},  {63'd0, tlast_b}, 64'd1);
    check({tag, "_fcnt"},  {62'd0, fcnt_b}, {62'd0, fc});
    check({tag, "_rden"},  {63'd0, rd_en_b}, {63'd0, rd});
  endtask

  initial begin
    reset_a = 1'b1; tready_a = 1'b0; flush_a = 1'b0; clr_a = 1'b0;
    reset_b = 1'b1; tready_b = 1'b1; flush_b = 1'b0; clr_b = 1'b0;

    push_a(wd(ln(8'h10,1,0), ln(8'h11,0,0), ln(8'h12,0,0), ln(8'h13,0,0)));
    push_a(wd(ln(8'h14,0,0), ln(8'h15,0,0), ln(8'h16,0,0), ln(8'h17,0,1)));
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b0;
      b0 = 8'hA0 + 8'(4*k);
      push_b(wd(ln(b0,1,0), ln(b0+8'd1,0,0), ln(b0+8'd2,0,0), ln(b0+8'd3,0,1)));
    end

    // reset state, FIFO already non-empty
    @(negedge clk); #1;
    check("rst_valid", {63'd0, tvalid_a}, 64'd0);
    check("rst_err",   {63'd0, err_a},    64'd0);
    check("rst_fcnt",  {48'd0, fcnt_a},   64'd0);
    check("rst_rden",  {63'd0, rd_en_a},  64'd0);

    // full throughput across a word boundary
    @(negedge clk); reset_a = 1'b0; tready_a = 1'b1; #1;
    check("t1_rden_first", {63'd0, rd_en_a},  64'd1);
    check("t1_idle_valid", {63'd0, tvalid_a}, 64'd0);
    @(negedge clk); #1;
    beat_a("t1_b0", 16'h1110, 1, 0);
    check("t1_rden_b0", {63'd0, rd_en_a}, 64'd0);
    @(negedge clk); #1;
    beat_a("t1_b1", 16'h1312, 0, 0);
    check("t1_rden_b1", {63'd0, rd_en_a}, 64'd1);
    @(negedge clk); #1;
    beat_a("t1_b2", 16'h1514, 0, 0);
    @(negedge clk); #1;
    beat_a("t1_b3", 16'h1716, 0, 1);
    check("t1_rden_empty", {63'd0, rd_en_a}, 64'd0);
    @(negedge clk); #1;
    check("t1_valid_end", {63'd0, tvalid_a}, 64'd0);
    check("t1_fcnt",      {48'd0, fcnt_a},   64'd1);
    check("t1_pops",      64'(rd_pulses_a),  64'd2);

    // backpressure on the last beat of a word
    push_a(wd(ln(8'h20,1,0), ln(8'h21,0,0), ln(8'h22,0,0), ln(8'h23,0,0)));
    push_a(wd(ln(8'h24,0,0), ln(8'h25,0,0), ln(8'h26,0,0), ln(8'h27,0,1)));
    @(negedge clk); #1;
    beat_a("t2_b0", 16'h2120, 1, 0);
    @(negedge clk); tready_a = 1'b0; #1;
    beat_a("t2_hold0", 16'h2322, 0, 0);
    check("t2_rden_hold0", {63'd0, rd_en_a}, 64'd0);
    @(negedge clk); #1;
    beat_a("t2_hold1", 16'h2322, 0, 0);
    check("t2_rden_hold1", {63'd0, rd_en_a}, 64'd0);
    @(negedge clk); tready_a = 1'b1; #1;
    beat_a("t2_b1", 16'h2322, 0, 0);
    check("t2_rden_go", {63'd0, rd_en_a}, 64'd1);
    @(negedge clk); #1;
    beat_a("t2_b2", 16'h2524, 0, 0);
    @(negedge clk); #1;
    beat_a("t2_b3", 16'h2726, 0, 1);
    @(negedge clk); #1;
    check("t2_valid_end", {63'd0, tvalid_a}, 64'd0);
    check("t2_fcnt",      {48'd0, fcnt_a},   64'd2);

    // framing error: sof on lane 1, then clear
    push_a(wd(ln(8'h30,0,0), ln(8'h31,1,0), ln(8'h32,0,0), ln(8'h33,0,0)));
    @(negedge clk); #1;
    beat_a("t3_b0", 16'h3130, 0, 0);
    check("t3_err_before", {63'd0, err_a}, 64'd0);
    @(negedge clk); clr_a = 1'b1; #1;
    check("t3_err_set", {63'd0, err_a}, 64'd1);
    beat_a("t3_b1", 16'h3332, 0, 0);
    @(negedge clk); clr_a = 1'b0; #1;
    check("t3_err_clr", {63'd0, err_a}, 64'd0);
    check("t3_valid_end", {63'd0, tvalid_a}, 64'd0);

    // eol on a non-last lane while clr_err is held: set wins
    push_a(wd(ln(8'h40,1,0), ln(8'h41,0,0), ln(8'h42,0,1), ln(8'h43,0,0)));
    @(negedge clk); #1;
    beat_a("t3e_b0", 16'h4140, 1, 0);
    check("t3e_err_before", {63'd0, err_a}, 64'd0);
    @(negedge clk); clr_a = 1'b1; #1;
    beat_a("t3e_b1", 16'h4342, 0, 0);
    @(negedge clk); #1;
    check("t3e_set_wins", {63'd0, err_a}, 64'd1);
    @(negedge clk); clr_a = 1'b0; #1;
    check("t3e_err_clr", {63'd0, err_a},  64'd0);
    check("t3e_fcnt",    {48'd0, fcnt_a}, 64'd2);

    // flush after beat 0 of a word
    push_a(wd(ln(8'h50,1,0), ln(8'h51,0,0), ln(8'h52,0,0), ln(8'h53,0,0)));
    push_a(wd(ln(8'h60,1,0), ln(8'h61,0,0), ln(8'h62,0,0), ln(8'h63,0,1)));
    @(negedge clk); flush_a = 1'b1; #1;
    beat_a("t4_b0", 16'h5150, 1, 0);
    check("t4_rden_flush0", {63'd0, rd_en_a}, 64'd0);
    @(negedge clk); #1;
    check("t4_valid_flushed", {63'd0, tvalid_a}, 64'd0);
    check("t4_rden_flush1",   {63'd0, rd_en_a},  64'd0);
    flush_a = 1'b0; #1;
    check("t4_rden_after", {63'd0, rd_en_a}, 64'd1);
    @(negedge clk); #1;
    beat_a("t4_next_b0", 16'h6160, 1, 0);
    @(negedge clk); #1;
    beat_a("t4_next_b1", 16'h6362, 0, 1);
    @(negedge clk); #1;
    check("t4_valid_end", {63'd0, tvalid_a}, 64'd0);
    check("t4_fcnt",      {48'd0, fcnt_a},   64'd3);

    // asynchronous reset mid-word with error and frame count pending
    push_a(wd(ln(8'h70,1,1), ln(8'h71,0,0), ln(8'h72,0,0), ln(8'h73,0,0)));
    push_a(wd(ln(8'h80,1,0), ln(8'h81,0,0), ln(8'h82,0,0), ln(8'h83,0,1)));
    @(negedge clk); #1;
    beat_a("t5_b0", 16'h7170, 1, 0);
    @(negedge clk); #1;
    beat_a("t5_b1", 16'h7372, 0, 0);
    check("t5_err_pre", {63'd0, err_a}, 64'd1);
    #1 reset_a = 1'b1;
    #1;
    check("t5_rst_valid", {63'd0, tvalid_a}, 64'd0);
    check("t5_rst_err",   {63'd0, err_a},    64'd0);
    check("t5_rst_fcnt",  {48'd0, fcnt_a},   64'd0);
    check("t5_rst_rden",  {63'd0, rd_en_a},  64'd0);
    @(negedge clk); reset_a = 1'b0; #1;
    check("t5_rden_rel",  {63'd0, rd_en_a},  64'd1);
    check("t5_valid_rel", {63'd0, tvalid_a}, 64'd0);
    @(negedge clk); #1;
    beat_a("t5_new_b0", 16'h8180, 1, 0);
    @(negedge clk); #1;
    beat_a("t5_new_b1", 16'h8382, 0, 1);
    @(negedge clk); #1;
    check("t5_idle_valid", {63'd0, tvalid_a}, 64'd0);
    check("t5_idle_rden",  {63'd0, rd_en_a},  64'd0);
    check("t5_fcnt",       {48'd0, fcnt_a},   64'd1);
    check("t5_err",        {63'd0, err_a},    64'd0);

    // single-beat words, 2-bit frame counter wraps
    check("t6_rst_rden", {63'd0, rd_en_b}, 64'd0);
    @(negedge clk); reset_b = 1'b0; #1;
    check("t6_rden_first", {63'd0, rd_en_b},  64'd1);
    check("t6_idle_valid", {63'd0, tvalid_b}, 64'd0);
    @(negedge clk); #1;
    beat_b("t6_w0", 32'hA3A2A1A0, 2'd0, 1);
    @(negedge clk); #1;
    beat_b("t6_w1", 32'hA7A6A5A4, 2'd1, 1);
    @(negedge clk); #1;
    beat_b("t6_w2", 32'hABAAA9A8, 2'd2, 1);
    @(negedge clk); #1;
    beat_b("t6_w3", 32'hAFAEADAC, 2'd3, 0);
    @(negedge clk); #1;
    check("t6_valid_end", {63'd0, tvalid_b}, 64'd0);
    check("t6_fcnt_wrap", {62'd0, fcnt_b},   64'd0);
    check("t6_rden_end",  {63'd0, rd_en_b},  64'd0);
    check("t6_err",       {63'd0, err_b},    64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
